// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for a 5-stage RISC-V pipeline. It decides
//   each cycle whether the PC advances, whether IF/ID loads, holds or takes a
//   bubble, and whether ID/EX takes a bubble. It arbitrates between load-use
//   hazards, EX-stage redirects, instruction-memory wait and an external halt.
//   A redirect that cannot be taken immediately is parked and replayed later.
//   Two saturating performance counters are maintained.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/id_rs2            source registers of the instruction in ID
//   id_uses_rs1/id_uses_rs2  ID instruction really reads rs1/rs2
//   ex_rd                    destination register of the instruction in EX
//   ex_mem_read              EX instruction is a load
//   ex_reg_write             EX instruction writes rd
//   ex_redirect              EX resolved a taken branch/jump
//   ex_redirect_target       redirect PC
//   imem_ready               instruction memory delivers a fetch this cycle
//   ext_halt                 debug/host halt request (level)
//   pc_en                    PC write enable
//   pc_sel_redirect          PC next = pc_redirect_target (else PC+4)
//   pc_redirect_target       redirect PC to load
//   if_id_en                 IF/ID load enable (0 = hold)
//   if_id_flush              IF/ID loads a bubble (overrides if_id_en)
//   id_ex_flush              ID/EX loads a bubble
//   ctrl_state               0=RUN, 1=REDIR_PEND, 2=HALT
//   stall_cycles             saturating count of cycles with pc_en=0
//   flush_events             saturating count of accepted redirects

module pipeline_hazard_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REGW-1:0]  id_rs1,
  input  logic [REGW-1:0]  id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REGW-1:0]  ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_redirect_target,
  input  logic             imem_ready,
  input  logic             ext_halt,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic [XLEN-1:0]  pc_redirect_target,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_REDIR_PEND = 2'd1,
    ST_HALT       = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]   pend_target_q, pend_target_d;
  logic [CNT_W-1:0]  stall_cycles_q, flush_events_q;
  logic              redirect_acc;
  logic              lu;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign lu = ex_mem_read & ex_reg_write & (ex_rd != '0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) |
               (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_en              = 1'b1;
    pc_sel_redirect    = 1'b0;
    pc_redirect_target = '0;
    if_id_en           = 1'b1;
    if_id_flush        = 1'b0;
    id_ex_flush        = 1'b0;
    state_d            = state_q;
    pend_valid_d       = pend_valid_q;
    pend_target_d      = pend_target_q;
    redirect_acc       = 1'b0;

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_redirect) begin
            redirect_acc = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            if (imem_ready) begin
              pc_sel_redirect    = 1'b1;
              pc_redirect_target = ex_redirect_target;
            end else begin
              pc_en         = 1'b0;
              pend_valid_d  = 1'b1;
              pend_target_d = ex_redirect_target;
              state_d       = ST_REDIR_PEND;
            end
          end else if (lu) begin
            // Hold IF/ID rather than bubble it, even if imem is not ready.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
          if (!ex_redirect && ext_halt) state_d = ST_HALT;
        end

        ST_REDIR_PEND: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (ex_redirect) begin
            redirect_acc  = 1'b1;
            pend_target_d = ex_redirect_target;
          end
          if (imem_ready) begin
            // A redirect arriving on the replay cycle is newer than the
            // parked one, so it is the one that gets replayed.
            pc_sel_redirect    = 1'b1;
            pc_redirect_target = ex_redirect ? ex_redirect_target : pend_target_q;
            pend_valid_d       = 1'b0;
            state_d            = ST_RUN;
          end else begin
            pc_en = 1'b0;
          end
        end

        ST_HALT: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          if (ex_redirect) begin
            redirect_acc  = 1'b1;
            pend_valid_d  = 1'b1;
            pend_target_d = ex_redirect_target;
            if_id_flush   = 1'b1;
          end
          if (!ext_halt) begin
            state_d = (pend_valid_q || ex_redirect) ? ST_REDIR_PEND : ST_RUN;
          end
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      pend_valid_q   <= 1'b0;
      pend_target_q  <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      if (!pc_en && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_ONE;
      end
      if (redirect_acc && (flush_events_q != '1)) begin
        flush_events_q <= flush_events_q + CNT_ONE;
      end
    end
  end

  assign ctrl_state   = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It decides each cycle whether the PC advances, whether the IF/ID register loads, holds or bubbles, and whether ID/EX is flushed. It arbitrates between load-use hazards, EX-stage redirects (taken branch/jump), instruction-memory wait and an external halt. A redirect that arrives while fetch is stalled or halted is latched and replayed later. Two saturating performance counters are also provided.

## Interface
- XLEN, 32, PC/target width
- REGW, 5, register index width
- CNT_W, 32, performance counter width
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  REGW  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads rs1/rs2
- ex_rd  in  REGW  destination of the instruction in EX
- ex_mem_read, ex_reg_write  in  1  the EX instruction is a load / writes rd
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle
- ex_redirect_target  in  XLEN  redirect PC
- imem_ready  in  1  instruction memory returns a valid fetch this cycle
- ext_halt  in  1  debug/host halt request (level)
- pc_en  out  1  PC register write enable
- pc_sel_redirect  out  1  PC next = pc_redirect_target (else PC+4)
- pc_redirect_target  out  XLEN  target to load when pc_sel_redirect=1
- if_id_en  out  1  IF/ID load enable (0 = hold)
- if_id_flush  out  1  IF/ID loads a bubble (overrides if_id_en)
- id_ex_flush  out  1  ID/EX loads a bubble
- ctrl_state  out  2  0=RUN, 1=REDIR_PEND, 2=HALT
- stall_cycles  out  CNT_W  cycles with pc_en=0
- flush_events  out  CNT_W  accepted redirects

## Operation
- lu = ex_mem_read & ex_reg_write & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Outputs are Mealy: a combinational function of the registered state, pend_valid/pend_target and the current inputs. The default is pc_en=1, if_id_en=1, all flush/select signals 0, and target=0.
- RUN, first match wins:
  - ex_redirect & imem_ready: pc_en=1, pc_sel_redirect=1, target=ex_redirect_target, if_id_flush=1, id_ex_flush=1. Next state is RUN.
  - ex_redirect & !imem_ready: pc_en=0, if_id_flush=1, id_ex_flush=1. Latch the target and set pend_valid. Next state is REDIR_PEND.
  - lu: pc_en=0, if_id_en=0 (hold), id_ex_flush=1. The lu hold takes precedence over imem bubbling.
  - !imem_ready: pc_en=0, if_id_flush=1.
  - After any of the above, if ext_halt=1 and there was no redirect this cycle, next state is HALT.
- REDIR_PEND:
  - if_id_flush=1 and id_ex_flush=1 every cycle.
  - While imem_ready=0: pc_en=0.
  - When imem_ready=1: pc_en=1, pc_sel_redirect=1, target=pend_target. Clear pend_valid; next state is RUN.
  - A new ex_redirect here overwrites pend_target (newest wins) and counts as a flush event.
- HALT:
  - pc_en=0, if_id_en=0, id_ex_flush=1.
  - ex_redirect latches pend_target/pend_valid and also asserts if_id_flush.
  - When ext_halt=0: next state is REDIR_PEND if pend_valid, else RUN.
- Counters: stall_cycles +1 on every cycle with pc_en=0. flush_events +1 on every cycle ex_redirect is accepted. Both saturate at all-ones and never wrap.

## Timing
- Control outputs have zero-cycle latency from the inputs. State, pending register and counters update on posedge clk.
- Load-use hold lasts exactly 1 cycle per hazard, since the load moves to MEM and lu drops.
- A redirect with imem_ready=1 costs 2 bubbles (IF/ID and ID/EX flushed in the same cycle).
- A pending redirect is replayed on the first cycle imem_ready=1 in REDIR_PEND.
- Reset (rst=1 sampled at posedge):
  - Next cycle: state=RUN, pend_valid=0, pend_target=0, counters=0.
  - While rst=1, outputs are forced to pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, pc_sel_redirect=0, target=0. Counters do not count.
  - Reset mid-REDIR_PEND or mid-HALT discards the pending redirect.
- Simultaneous ex_redirect + lu: the redirect wins and no hold occurs. Simultaneous ex_redirect + ext_halt in RUN: the redirect is serviced and HALT is entered next cycle only if ext_halt is still high.

## Test plan
- Load x5, then `add x6,x5,x1` in ID (ex_rd=5, ex_mem_read=1, id_rs1=5) -> 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1. Same case with ex_rd=0 -> no stall.
- ex_redirect=1, target=0x0000_0100, imem_ready=1 -> pc_sel_redirect=1, target=0x100, both flushes; flush_events=1; state stays RUN.
- ex_redirect with target 0x200 and imem_ready=0 for 3 cycles -> state=REDIR_PEND, pc_en=0 for 3 cycles; on cycle 4 with imem_ready=1 -> pc_sel_redirect=1, target=0x200, then RUN; stall_cycles=3.
- ext_halt high for 4 cycles with ex_redirect (target 0x300) on HALT cycle 2 -> pc_en=0 throughout; after ext_halt drops -> REDIR_PEND, replay 0x300.
- Assert rst during REDIR_PEND -> next cycle state=RUN, counters=0, no replay of the old target.
- Preload stall_cycles near max (force, or CNT_W=4 build) and hold imem_ready=0 -> counter sticks at all-ones (0xF).
